unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the CPU instruction-fetch side (I) and the load/store side (D).
- Arbitrates round-robin, registers the winning request, and issues it to the SRAM.
- Waits the SRAM read latency, then returns data with a one-cycle ack pulse to the winner.
- Sits between the CPU core's instr_*/data_* ports and a single memory macro; the core stalls while its req is high and its ack is low.

Parameters:
ADDR_WIDTH, 32, width of all address buses.
DATA_WIDTH, 32, width of data buses; the write strobe is DATA_WIDTH/8 bits.
MEM_LATENCY, 1, cycles from the SRAM read strobe to valid mem_do; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
i_req  in  1  instruction fetch request; held high until i_ack.
i_addr  in  ADDR_WIDTH  fetch address; stable while i_req is high.
i_ack  out  1  one-cycle pulse; fetch complete.
i_rdata  out  DATA_WIDTH  fetched word; valid while i_ack is high.
d_req  in  1  data request; held high until d_ack.
d_we  in  DATA_WIDTH/8  byte write strobe; all-zero means read.
d_addr  in  ADDR_WIDTH  data address; stable while d_req is high.
d_wdata  in  DATA_WIDTH  store data.
d_ack  out  1  one-cycle pulse; load or store complete.
d_rdata  out  DATA_WIDTH  load word; valid while d_ack is high.
mem_read  out  1  SRAM read strobe.
mem_write  out  DATA_WIDTH/8  SRAM byte write strobe.
mem_addr  out  ADDR_WIDTH  SRAM address.
mem_di  out  DATA_WIDTH  SRAM write data.
mem_do  in  DATA_WIDTH  SRAM read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - every output 0;
  - state = IDLE;
  - last_owner = D, so I wins the first tie;
  - wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the side that is not last_owner.
  - On a grant: latch owner, address, we (always 0 for I) and wdata; set last_owner = owner; go to ISSUE.
- ISSUE, exactly one cycle:
  - mem_addr = latched address.
  - Read: mem_read = 1, load counter with MEM_LATENCY, go to WAIT.
  - Write: mem_write = latched we, mem_di = latched wdata, go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter == 1 (issue cycle + MEM_LATENCY), capture mem_do into the owner's rdata register and go to RESP.
- RESP, exactly one cycle:
  - The owner's ack = 1, and its rdata holds the captured word.
  - The non-owner's ack and rdata are unchanged.
  - Go to IDLE. No arbitration takes place in RESP, so the just-acked requester can drop req without being re-granted.
- Outside ISSUE, mem_read and mem_write are 0. mem_addr and mem_di hold their last values.
- Latency, counted from the IDLE cycle A in which req is sampled:
  - read: ISSUE at A+1, data at A+1+MEM_LATENCY, ack at A+2+MEM_LATENCY;
  - write: ISSUE at A+1, ack at A+2.
- Throughput: back-to-back grants are at least 3 cycles apart for writes and 3+MEM_LATENCY cycles apart for reads.
- Round-robin: while both requesters stay high, grants strictly alternate, so neither side waits more than one foreign transaction.
- A request that arrives during ISSUE, WAIT or RESP is sampled at the next IDLE.
- Dropping req before ack: the latched transaction still completes and the ack still pulses; the requester must ignore it.
- i_rdata and d_rdata retain their last captured value between acks.
- Reset mid-operation:
  - immediate return to IDLE with all outputs 0;
  - the in-flight transaction is discarded with no ack;
  - an in-flight write strobe is deasserted immediately;
  - mem_do is ignored.

Test Plan:
1. Reset, then i_req=1, i_addr=0x0000_0010, mem_do=0xDEAD_BEEF with MEM_LATENCY=1 -> mem_read=1 and mem_addr=0x10 at A+1; i_ack=1 and i_rdata=0xDEAD_BEEF at A+3, for exactly one cycle; d_ack stays 0.
2. d_req=1, d_we=4'b0011, d_addr=0x100, d_wdata=0x1234_5678 -> at A+1 mem_write=4'b0011, mem_addr=0x100, mem_di=0x1234_5678, mem_read=0; d_ack=1 at A+2; mem_write=0 at A+2.
3. i_req and d_req both held high from reset for 4 transactions -> grant order I, D, I, D; every ack is preceded by the matching mem_addr; no lost or duplicated ack.
4. MEM_LATENCY=3, d_req read of 0x200, mem_do valid only at ISSUE+3 = 0xCAFE_0001 with garbage before -> d_rdata=0xCAFE_0001 with d_ack at A+5.
5. Assert rst during WAIT of an I read, then release -> all outputs 0 immediately; no i_ack; the next i_req after release is granted from IDLE with normal latency.
6. d_req drops during WAIT of a D read -> d_ack still pulses once; a pending i_req is granted in the IDLE cycle immediately after RESP.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin I/D arbiter in front of one single-port synchronous SRAM
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_ack,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic [DATA_WIDTH/8-1:0] d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ack,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_read,
    output logic [DATA_WIDTH/8-1:0] mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_di,
    input  logic [DATA_WIDTH-1:0]   mem_do
);

    localparam int WE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Counter is 4 bits wide because the SRAM latency is limited to 1..15.
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    logic [1:0]          r_state;
    logic                r_owner;
    logic                r_last_owner;
    logic [WE_WIDTH-1:0] r_we;
    logic [3:0]          r_cnt;

    logic                w_grant_valid;
    logic                w_grant_owner;
    logic [WE_WIDTH-1:0] w_grant_we;
    logic                w_grant_is_read;

    // Round-robin pick: a lone requester wins outright, a tie goes to the side that did not win last.
    always_comb begin
        w_grant_valid = i_req | d_req;
        w_grant_owner = OWN_I;
        if (i_req && d_req) begin
            w_grant_owner = ~r_last_owner;
        end else if (d_req) begin
            w_grant_owner = OWN_D;
        end
        w_grant_we      = (w_grant_owner == OWN_D) ? d_we : '0;
        w_grant_is_read = (w_grant_we == '0);
    end

    // Transaction sequencer: grant in IDLE, strobe the SRAM for one cycle, wait out the read latency, ack once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_D;
            r_we         <= '0;
            r_cnt        <= '0;
            i_ack        <= 1'b0;
            i_rdata      <= '0;
            d_ack        <= 1'b0;
            d_rdata      <= '0;
            mem_read     <= 1'b0;
            mem_write    <= '0;
            mem_addr     <= '0;
            mem_di       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_owner;
                        r_last_owner <= w_grant_owner;
                        r_we         <= w_grant_we;
                        // The SRAM strobes are registered here so they are live exactly during ISSUE.
                        mem_addr     <= (w_grant_owner == OWN_D) ? d_addr : i_addr;
                        if (w_grant_is_read) begin
                            mem_read <= 1'b1;
                        end else begin
                            mem_write <= w_grant_we;
                            mem_di    <= d_wdata;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mem_read  <= 1'b0;
                    mem_write <= '0;
                    if (r_we == '0) begin
                        r_cnt   <= LAT;
                        r_state <= S_WAIT;
                    end else begin
                        // A store needs no SRAM turnaround, so it acks right after the write strobe.
                        if (r_owner == OWN_D) begin
                            d_ack <= 1'b1;
                        end else begin
                            i_ack <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        if (r_owner == OWN_D) begin
                            d_rdata <= mem_do;
                            d_ack   <= 1'b1;
                        end else begin
                            i_rdata <= mem_do;
                            i_ack   <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // No arbitration here, so a requester dropping req on its ack is never re-granted.
                    i_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WW  = DW / 8;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_ack;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic [WW-1:0] d_we = '0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_read;
    logic [WW-1:0] mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_di;
    logic [DW-1:0] mem_do = '0;

    logic          x_i_req = 1'b0;
    logic [AW-1:0] x_i_addr = '0;
    logic          x_i_ack;
    logic [DW-1:0] x_i_rdata;
    logic          x_d_req = 1'b0;
    logic [WW-1:0] x_d_we = '0;
    logic [AW-1:0] x_d_addr = '0;
    logic [DW-1:0] x_d_wdata = '0;
    logic          x_d_ack;
    logic [DW-1:0] x_d_rdata;
    logic          x_mem_read;
    logic [WW-1:0] x_mem_write;
    logic [AW-1:0] x_mem_addr;
    logic [DW-1:0] x_mem_di;
    logic [DW-1:0] x_mem_do = '0;

    int n_assert = 0;
    int n_fail   = 0;

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_di(mem_di), .mem_do(mem_do)
    );

    unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(x_i_req), .i_addr(x_i_addr), .i_ack(x_i_ack), .i_rdata(x_i_rdata),
        .d_req(x_d_req), .d_we(x_d_we), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_ack(x_d_ack), .d_rdata(x_d_rdata),
        .mem_read(x_mem_read), .mem_write(x_mem_write), .mem_addr(x_mem_addr),
        .mem_di(x_mem_di), .mem_do(x_mem_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level model: each grant at IDLE cycle a fixes strobe, capture and ack cycles by arithmetic.
    int            m_cyc = 0;
    int            m_c = 0;
    int            m_next_idle = 0;
    int            m_a = 0;
    int            m_ack_cyc = 0;
    logic          m_active = 1'b0;
    logic          m_read = 1'b0;
    logic          m_owner = 1'b0;
    logic          m_last = 1'b1;
    logic [WW-1:0] m_we = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata [2];

    logic          e_i_ack = 1'b0;
    logic          e_d_ack = 1'b0;
    logic [DW-1:0] e_i_rdata = '0;
    logic [DW-1:0] e_d_rdata = '0;
    logic          e_mem_read = 1'b0;
    logic [WW-1:0] e_mem_write = '0;
    logic [AW-1:0] e_mem_addr = '0;
    logic [DW-1:0] e_mem_di = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc = 0; m_next_idle = 0; m_active = 1'b0; m_last = 1'b1;
                m_rdata[0] = '0; m_rdata[1] = '0;
                e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_rdata = '0; e_d_rdata = '0;
                e_mem_read = 1'b0; e_mem_write = '0; e_mem_addr = '0; e_mem_di = '0;
            end else begin
                m_c = m_cyc;
                if (m_active && m_read && m_c == m_a + 1 + LAT) m_rdata[m_owner] = mem_do;
                if (m_c == m_next_idle) begin
                    if (i_req || d_req) begin
                        m_owner = (i_req && d_req) ? ~m_last : d_req;
                        m_last = m_owner;
                        m_active = 1'b1;
                        m_a = m_c;
                        m_we = m_owner ? d_we : '0;
                        m_read = (m_we == '0);
                        m_addr = m_owner ? d_addr : i_addr;
                        m_wdata = d_wdata;
                        m_next_idle = m_c + (m_read ? 3 + LAT : 3);
                    end else begin
                        m_next_idle = m_c + 1;
                    end
                end
                m_cyc = m_c + 1;
                m_ack_cyc = m_a + (m_read ? 2 + LAT : 2);
                e_mem_read  = m_active && m_read && (m_cyc == m_a + 1);
                e_mem_write = (m_active && !m_read && (m_cyc == m_a + 1)) ? m_we : '0;
                if (m_active && (m_cyc == m_a + 1)) begin
                    e_mem_addr = m_addr;
                    if (!m_read) e_mem_di = m_wdata;
                end
                e_i_ack = m_active && (m_cyc == m_ack_cyc) && (m_owner == 1'b0);
                e_d_ack = m_active && (m_cyc == m_ack_cyc) && (m_owner == 1'b1);
                e_i_rdata = m_rdata[0];
                e_d_rdata = m_rdata[1];
            end
        end
    end

    // Cycle-by-cycle comparison of the latency-1 instance against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("cyc i_ack", i_ack, e_i_ack);
            check("cyc d_ack", d_ack, e_d_ack);
            check("cyc i_rdata", i_rdata, e_i_rdata);
            check("cyc d_rdata", d_rdata, e_d_rdata);
            check("cyc mem_read", mem_read, e_mem_read);
            check("cyc mem_write", mem_write, e_mem_write);
            check("cyc mem_addr", mem_addr, e_mem_addr);
            check("cyc mem_di", mem_di, e_mem_di);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int            ack_cyc [$];
    logic          ack_side [$];
    logic [3:0]    exp_side = 4'b1010;
    logic [DW-1:0] prev_do;

    initial begin
        // 1: reset values, then a single I read
        rst = 1'b1;
        repeat (3) tick();
        check("rst i_ack", i_ack, 0);
        check("rst d_ack", d_ack, 0);
        check("rst i_rdata", i_rdata, 0);
        check("rst d_rdata", d_rdata, 0);
        check("rst mem_read", mem_read, 0);
        check("rst mem_write", mem_write, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_di", mem_di, 0);
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h10; mem_do = 32'hDEAD_BEEF;
        tick();
        check("t1 mem_read A+1", mem_read, 1);
        check("t1 mem_addr A+1", mem_addr, 32'h10);
        tick();
        check("t1 i_ack A+2", i_ack, 0);
        tick();
        check("t1 i_ack A+3", i_ack, 1);
        check("t1 i_rdata A+3", i_rdata, 32'hDEAD_BEEF);
        check("t1 d_ack A+3", d_ack, 0);
        i_req = 1'b0;
        tick();
        check("t1 i_ack A+4", i_ack, 0);

        // 2: byte-masked D write
        d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h100; d_wdata = 32'h1234_5678;
        tick();
        check("t2 mem_write A+1", mem_write, 4'b0011);
        check("t2 mem_addr A+1", mem_addr, 32'h100);
        check("t2 mem_di A+1", mem_di, 32'h1234_5678);
        check("t2 mem_read A+1", mem_read, 0);
        tick();
        check("t2 d_ack A+2", d_ack, 1);
        check("t2 mem_write A+2", mem_write, 0);
        check("t2 i_rdata held", i_rdata, 32'hDEAD_BEEF);
        check("t2 mem_di held", mem_di, 32'h1234_5678);
        d_req = 1'b0; d_we = '0;
        tick();
        check("t2 d_ack A+3", d_ack, 0);

        // 3: both sides requesting from reset, grants must alternate I, D, I, D
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h40; d_addr = 32'h80; d_we = '0;
        mem_do = 32'h5A5A_0000;
        prev_do = mem_do;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (i_ack) begin
                ack_cyc.push_back(k); ack_side.push_back(1'b0);
                check("t3 i addr before ack", mem_addr, 32'h40);
                check("t3 i_rdata", i_rdata, prev_do);
            end
            if (d_ack) begin
                ack_cyc.push_back(k); ack_side.push_back(1'b1);
                check("t3 d addr before ack", mem_addr, 32'h80);
                check("t3 d_rdata", d_rdata, prev_do);
            end
            mem_do = 32'h5A5A_0000 + 32'(k);
            prev_do = mem_do;
        end
        i_req = 1'b0; d_req = 1'b0;
        check("t3 ack count", ack_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_cyc.size()) begin
                check("t3 ack cycle", ack_cyc[i], 3 + 4 * i);
                check("t3 ack side", ack_side[i], exp_side[i]);
            end
        end

        // 5: reset during WAIT of an I read, and during ISSUE of a write
        i_req = 1'b1; i_addr = 32'h30; mem_do = 32'h1111_1111;
        tick();
        check("t5 mem_read issue", mem_read, 1);
        tick();
        rst = 1'b1;
        #1;
        check("t5 rst mem_read", mem_read, 0);
        check("t5 rst mem_addr", mem_addr, 0);
        check("t5 rst i_rdata", i_rdata, 0);
        check("t5 rst d_rdata", d_rdata, 0);
        check("t5 rst i_ack", i_ack, 0);
        tick();
        check("t5 no i_ack in rst", i_ack, 0);
        rst = 1'b0; mem_do = 32'h0BAD_F00D;
        tick();
        check("t5 mem_read A+1", mem_read, 1);
        check("t5 mem_addr A+1", mem_addr, 32'h30);
        tick();
        check("t5 i_ack A+2", i_ack, 0);
        tick();
        check("t5 i_ack A+3", i_ack, 1);
        check("t5 i_rdata A+3", i_rdata, 32'h0BAD_F00D);
        i_req = 1'b0;
        tick();
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h300; d_wdata = 32'hA5A5_A5A5;
        tick();
        check("t5 mem_write issue", mem_write, 4'hF);
        rst = 1'b1;
        #1;
        check("t5 rst mem_write", mem_write, 0);
        check("t5 rst mem_di", mem_di, 0);
        tick();
        rst = 1'b0; d_req = 1'b0; d_we = '0;
        tick();
        check("t5 no d_ack after rst", d_ack, 0);

        // 6: D read whose requester drops req during WAIT, with I pending
        d_req = 1'b1; d_we = '0; d_addr = 32'h200; mem_do = 32'h7777_7777;
        tick();
        i_req = 1'b1; i_addr = 32'h44;
        tick();
        d_req = 1'b0;
        tick();
        check("t6 d_ack A+3", d_ack, 1);
        check("t6 d_rdata A+3", d_rdata, 32'h7777_7777);
        tick();
        check("t6 d_ack A+4", d_ack, 0);
        tick();
        check("t6 i mem_read A+5", mem_read, 1);
        check("t6 i mem_addr A+5", mem_addr, 32'h44);
        tick();
        tick();
        check("t6 i_ack A+7", i_ack, 1);
        check("t6 i_rdata A+7", i_rdata, 32'h7777_7777);
        i_req = 1'b0;
        tick();

        // 4: latency-3 instance, only the word present at ISSUE+3 may be captured
        x_d_req = 1'b1; x_d_we = '0; x_d_addr = 32'h200; x_mem_do = 32'hBAD0_0000;
        for (int j = 1; j <= 7; j++) begin
            tick();
            x_mem_do = (j == 4) ? 32'hCAFE_0001 : 32'hBAD0_0000 + 32'(j);
            if (j == 1) begin
                check("t4 mem_read A+1", x_mem_read, 1);
                check("t4 mem_addr A+1", x_mem_addr, 32'h200);
            end
            check("t4 d_ack", x_d_ack, (j == 5) ? 1 : 0);
            check("t4 i_ack", x_i_ack, 0);
            if (j == 5) begin
                check("t4 d_rdata A+5", x_d_rdata, 32'hCAFE_0001);
                x_d_req = 1'b0;
            end
        end
        check("t4 d_rdata held", x_d_rdata, 32'hCAFE_0001);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
